mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
Shares the single memory-side line bus (C2 command, A2 address, D2 data) between two line-level requesters, e.g. the data cache and a second cache or a DMA. Each requester issues READ_LINE or WRITE_LINE on a 15-bit line address, and the block serialises whole-line transactions. A line is 16 bytes, moved as BEATS x 16-bit beats. Separate in/out ports replace tristate; bus wrappers handle the z-drive outside this block.

Parameters:
BEATS, 8, 16-bit beats per line (line size 16 B)
TIMEOUT, 255, max cycles waiting for memory RESPONSE before abort (8-bit counter)

Ports:
clk  in  1  clock, all state changes on rising edge
RESET  in  1  asynchronous, active-low reset
rq0_cmd  in  2  requester 0 command: 0 NOP, 2 READ_LINE, 3 WRITE_LINE; 1 treated as NOP
rq0_addr  in  15  requester 0 line address {tag[9:0], set[4:0]}
rq0_wdata  in  16  requester 0 write beat, high byte = lower byte address
rq1_cmd  in  2  requester 1 command, same encoding
rq1_addr  in  15  requester 1 line address
rq1_wdata  in  16  requester 1 write beat
rq_gnt  out  2  one-hot grant pulse, 1 cycle, bit i = requester i
rq_beat  out  2  one-hot beat strobe: write beat consumed / read beat valid
rq_rdata  out  16  read beat data, valid when any rq_beat bit set on a read
rq_done  out  2  one-hot transaction-complete pulse
rq_err  out  2  one-hot timeout pulse, coincident with rq_done
mem_cmd_o  out  2  memory command: 0 NOP, 2 READ_LINE, 3 WRITE_LINE
mem_addr_o  out  15  memory line address
mem_wdata_o  out  16  memory write beat
mem_cmd_i  in  2  memory response: 1 RESPONSE, else idle
mem_rdata_i  in  16  memory read beat

Behaviour:
- Reset (RESET=0, async): state IDLE; all outputs 0 (mem_cmd_o = NOP); beat and timeout counters 0; rr pointer = 1, so requester 0 wins the first tie.
- Requester protocol: hold cmd/addr stable until own rq_gnt bit pulses. cmd and addr are captured at grant. For writes, beat k's data is presented on rq_wdata and held until the k-th rq_beat pulse.
- States: IDLE, ISSUE, WDATA, WAIT, RDATA.
- IDLE: valid request from one requester grants that requester. Valid requests from both grant the one not equal to rr, then rr is set to the granted index. Grant transitions to ISSUE; no request stays IDLE.
- ISSUE (1 cycle): rq_gnt[i]=1; mem_cmd_o = captured cmd; mem_addr_o = captured addr.
  - WRITE_LINE -> WDATA with beat=0.
  - READ_LINE -> WAIT.
- WDATA (BEATS cycles): mem_wdata_o = rq{i}_wdata combinationally; rq_beat[i]=1 each cycle; beat++. At beat = BEATS-1 -> WAIT.
- WAIT: timeout counter increments each cycle; mem_cmd_o = NOP.
  - Read, mem_cmd_i=1: rq_rdata = mem_rdata_i, rq_beat[i]=1 (beat 0), beat=1 -> RDATA.
  - Write, mem_cmd_i=1: rq_done[i]=1 -> IDLE.
  - Counter reaching TIMEOUT with no response: rq_done[i]=1, rq_err[i]=1 -> IDLE, with no beats delivered.
- RDATA: each cycle rq_rdata = mem_rdata_i, rq_beat[i]=1, beat++. rq_done[i] pulses with the final beat (beat = BEATS-1), then -> IDLE. mem_cmd_i is not rechecked during RDATA.
- Latency: read = 1 ISSUE cycle + memory wait + BEATS cycles. Write = 1 + BEATS + wait + 1 response cycle. Min IDLE gap between transactions: 1 cycle (done -> IDLE -> ISSUE).
- mem_addr_o = 0 outside ISSUE; mem_wdata_o = 0 outside WDATA; rq_rdata = 0 when no read beat.
- Requests arriving while busy wait; they are not queued and must be held.
- mem_cmd_i=1 while in IDLE/ISSUE/WDATA is ignored.
- Reset mid-transaction aborts immediately with no done/err pulse; requesters must reissue.
- Timeout counter and beat counter clear on every entry to ISSUE.

Test Plan:
- rq0 READ_LINE addr 15'h1234; memory answers 5 cycles after ISSUE with beats 16'h0001..16'h0008 -> one rq_gnt[0] pulse, mem_addr_o=15'h1234 for exactly 1 cycle, 8 rq_beat[0] pulses with rq_rdata 1..8, rq_done[0] on the 8th, no err.
- rq1 WRITE_LINE addr 15'h0021, wdata A0..A7 advanced on rq_beat -> mem_wdata_o = A0..A7 on 8 consecutive cycles; RESPONSE 3 cycles later gives rq_done[1] in that cycle.
- Both request READ_LINE in the same cycle out of reset -> rq0 granted first, rq1 granted 1 cycle after rq0's done. Repeating both simultaneously alternates 1,0,1.
- rq0 READ_LINE with memory never responding -> after 255 WAIT cycles, rq_done[0] and rq_err[0] pulse together, no rq_beat; next request is granted normally.
- RESET low during beat 4 of a read -> all outputs 0 asynchronously, state IDLE, no done pulse; after release a new rq1 request is granted on the first edge.
- rq0_cmd=1 (invalid) with rq1 idle -> no grant, mem_cmd_o stays 0.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between two line-level requesters, the memory-side line bus and the arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the requesters and memory.
interface mem_bus_arbiter_if;
  logic [1:0]  rq0_cmd;
  logic [14:0] rq0_addr;
  logic [15:0] rq0_wdata;
  logic [1:0]  rq1_cmd;
  logic [14:0] rq1_addr;
  logic [15:0] rq1_wdata;
  logic [1:0]  rq_gnt;
  logic [1:0]  rq_beat;
  logic [15:0] rq_rdata;
  logic [1:0]  rq_done;
  logic [1:0]  rq_err;
  logic [1:0]  mem_cmd_o;
  logic [14:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [1:0]  mem_cmd_i;
  logic [15:0] mem_rdata_i;

  modport master (
    input  rq0_cmd, rq0_addr, rq0_wdata,
    input  rq1_cmd, rq1_addr, rq1_wdata,
    input  mem_cmd_i, mem_rdata_i,
    output rq_gnt, rq_beat, rq_rdata, rq_done, rq_err,
    output mem_cmd_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output rq0_cmd, rq0_addr, rq0_wdata,
    output rq1_cmd, rq1_addr, rq1_wdata,
    output mem_cmd_i, mem_rdata_i,
    input  rq_gnt, rq_beat, rq_rdata, rq_done, rq_err,
    input  mem_cmd_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the memory line bus. It serialises whole-line READ_LINE and WRITE_LINE
// transactions with round-robin tie-break and a response timeout.
module mem_bus_arbiter #(
  parameter int BEATS   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              RESET,
  mem_bus_arbiter_if.master bus
);

  localparam int             BW           = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]  LAST_BEAT    = BW'(BEATS - 1);
  localparam logic [7:0]     TMO_LIMIT    = 8'(TIMEOUT);
  localparam logic [1:0]     CMD_RESPONSE = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WDATA,
    S_WAIT,
    S_RDATA
  } state_e;

  state_e          state_q;
  logic            owner_q;
  logic            is_write_q;
  logic            rr_q;
  logic [14:0]     addr_q;
  logic [BW-1:0]   beat_q;
  logic [7:0]      tmo_q;

  logic            rq0_vld;
  logic            rq1_vld;
  logic            gnt_idx_d;
  logic            rsp;
  logic            last_beat;
  logic            tmo_hit;
  logic [1:0]      owner_oh;

  // Commands 2 and 3 are the only valid requests. Bit 1 alone separates them from NOP and 1.
  assign rq0_vld   = bus.rq0_cmd[1];
  assign rq1_vld   = bus.rq1_cmd[1];
  // On a tie, the requester that is not rr_q wins.
  assign gnt_idx_d = rq1_vld & (~rq0_vld | ~rr_q);
  assign rsp       = (bus.mem_cmd_i == CMD_RESPONSE);
  assign last_beat = (beat_q == LAST_BEAT);
  assign tmo_hit   = (tmo_q == TMO_LIMIT);
  assign owner_oh  = owner_q ? 2'b10 : 2'b01;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values and the update order inside this block does not matter.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      is_write_q <= 1'b0;
      rr_q       <= 1'b1;
      addr_q     <= '0;
      beat_q     <= '0;
      tmo_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rq0_vld || rq1_vld) begin
            owner_q    <= gnt_idx_d;
            is_write_q <= gnt_idx_d ? bus.rq1_cmd[0] : bus.rq0_cmd[0];
            addr_q     <= gnt_idx_d ? bus.rq1_addr : bus.rq0_addr;
            if (rq0_vld && rq1_vld) rr_q <= gnt_idx_d;
            beat_q     <= '0;
            tmo_q      <= '0;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= is_write_q ? S_WDATA : S_WAIT;
        S_WDATA: begin
          if (last_beat) begin
            beat_q  <= '0;
            state_q <= S_WAIT;
          end else begin
            beat_q  <= beat_q + BW'(1);
          end
        end
        S_WAIT: begin
          tmo_q <= tmo_q + 8'd1;
          if (rsp) begin
            if (is_write_q || last_beat) begin
              state_q <= S_IDLE;
            end else begin
              beat_q  <= BW'(1);
              state_q <= S_RDATA;
            end
          end else if (tmo_hit) begin
            state_q <= S_IDLE;
          end
        end
        S_RDATA: begin
          beat_q <= beat_q + BW'(1);
          if (last_beat) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case, so no path can leave one unassigned
  // and infer a latch.
  always_comb begin
    bus.rq_gnt      = '0;
    bus.rq_beat     = '0;
    bus.rq_rdata    = '0;
    bus.rq_done     = '0;
    bus.rq_err      = '0;
    bus.mem_cmd_o   = '0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    case (state_q)
      S_ISSUE: begin
        bus.rq_gnt     = owner_oh;
        bus.mem_cmd_o  = {1'b1, is_write_q};
        bus.mem_addr_o = addr_q;
      end
      S_WDATA: begin
        bus.rq_beat     = owner_oh;
        bus.mem_wdata_o = owner_q ? bus.rq1_wdata : bus.rq0_wdata;
      end
      S_WAIT: begin
        if (rsp) begin
          if (is_write_q) begin
            bus.rq_done = owner_oh;
          end else begin
            bus.rq_beat  = owner_oh;
            bus.rq_rdata = bus.mem_rdata_i;
            if (last_beat) bus.rq_done = owner_oh;
          end
        end else if (tmo_hit) begin
          bus.rq_done = owner_oh;
          bus.rq_err  = owner_oh;
        end
      end
      S_RDATA: begin
        bus.rq_beat  = owner_oh;
        bus.rq_rdata = bus.mem_rdata_i;
        if (last_beat) bus.rq_done = owner_oh;
      end
      default: ;
    endcase
  end

endmodule
